alu_op_issuer: RTL and testbench

// - Initiator side of the 4-bit ALU interface (a, b, ctrl -> res, car, of).
// - Accepts operation requests on a valid/ready channel and drives registered operands and opcode into the combinational ALU.
// - Captures the ALU result one cycle later and returns it on a valid/ready response channel.
// - Keeps sticky carry/overflow status and a count of completed operations for the board-level debug display.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_op_issuer.sv | 132 +++++++++++++
 tb/tb_alu_op_issuer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU interface.
//   alu_op_e       : ALU opcode encoding driven on the ctrl bus
//   issuer_state_e : operation sequencing states of alu_op_issuer
//   ALU_W          : operand/result width of the ALU
package alu_pkg;

  localparam int unsigned ALU_W = 4;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    NOT = 3'b010,
    AND = 3'b011,
    OR  = 3'b100,
    XOR = 3'b101,
    LT  = 3'b110,
    EQ  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CAPT,
    RESP
  } issuer_state_e;

endpackage

// File: rtl/alu_op_issuer.sv
// Initiator side of the combinational ALU interface.
// Accepts one operation on the req channel, drives registered operands and
// opcode to the ALU, captures the result after one settle cycle and returns
// it on the rsp channel. Also keeps sticky carry/overflow flags and a
// saturating count of completed operations.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   req_valid/req_ready          request handshake
//   req_a, req_b, req_op         operation request
//   alu_a, alu_b, alu_ctrl       registered ALU inputs (held between ops)
//   alu_res, alu_car, alu_of     combinational ALU outputs
//   rsp_valid/rsp_ready          response handshake
//   rsp_res, rsp_car, rsp_of,
//   rsp_zero                     captured result
//   clr_flags                    synchronous clear of sticky flags
//   sticky_car, sticky_of        sticky status
//   op_count                     completed operations, saturating
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int unsigned W     = ALU_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  input  alu_op_e          req_op,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output alu_op_e          alu_ctrl,
  input  logic [W-1:0]     alu_res,
  input  logic             alu_car,
  input  logic             alu_of,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_res,
  output logic             rsp_car,
  output logic             rsp_of,
  output logic             rsp_zero,
  input  logic             clr_flags,
  output logic             sticky_car,
  output logic             sticky_of,
  output logic [CNT_W-1:0] op_count
);

  issuer_state_e state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs are pure state decodes, so reset forces req_ready=1
  // and rsp_valid=0 without waiting for a clock.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = DRIVE;
      end
      DRIVE: state_nxt = CAPT;
      CAPT:  state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ALU inputs change only on an accept and hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= ADD;
    end else if (state == IDLE && req_valid) begin
      alu_a    <= req_a;
      alu_b    <= req_b;
      alu_ctrl <= req_op;
    end
  end

  // The ALU has had the whole DRIVE cycle to settle; sample it leaving DRIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_res  <= '0;
      rsp_car  <= 1'b0;
      rsp_of   <= 1'b0;
      rsp_zero <= 1'b0;
    end else if (state == DRIVE) begin
      rsp_res  <= alu_res;
      rsp_car  <= alu_car;
      rsp_of   <= alu_of;
      rsp_zero <= (alu_res == '0);
    end
  end

  // In CAPT the clear applies to the old value only, so a simultaneous set
  // still leaves the flag at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_car <= 1'b0;
      sticky_of  <= 1'b0;
    end else if (state == CAPT) begin
      sticky_car <= (sticky_car & ~clr_flags) | rsp_car;
      sticky_of  <= (sticky_of  & ~clr_flags) | rsp_of;
    end else if (clr_flags) begin
      sticky_car <= 1'b0;
      sticky_of  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (state == CAPT && op_count != '1) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
module tb_alu_op_issuer;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a, req_b;
  alu_op_e    req_op;
  logic [3:0] alu_a, alu_b;
  alu_op_e    alu_ctrl;
  logic [3:0] alu_res;
  logic       alu_car, alu_of;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_res;
  logic       rsp_car, rsp_of, rsp_zero;
  logic       clr_flags;
  logic       sticky_car, sticky_of;
  logic [1:0] op_count;

  alu_op_issuer #(.W(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_res(alu_res), .alu_car(alu_car), .alu_of(alu_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_car(rsp_car), .rsp_of(rsp_of), .rsp_zero(rsp_zero),
    .clr_flags(clr_flags),
    .sticky_car(sticky_car), .sticky_of(sticky_of),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 4-bit ALU standing in for the one the parent places beside the issuer.
  logic [4:0] s;
  always_comb begin
    s       = '0;
    alu_res = '0;
    alu_car = 1'b0;
    alu_of  = 1'b0;
    case (alu_ctrl)
      ADD: begin
        s       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_res = s[3:0];
        alu_car = s[4];
        alu_of  = (alu_a[3] == alu_b[3]) && (s[3] != alu_a[3]);
      end
      SUB: begin
        s       = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        alu_res = s[3:0];
        alu_car = s[4];
        alu_of  = (alu_a[3] != alu_b[3]) && (s[3] != alu_a[3]);
      end
      NOT: alu_res = ~alu_a;
      AND: alu_res = alu_a & alu_b;
      OR:  alu_res = alu_a | alu_b;
      XOR: alu_res = alu_a ^ alu_b;
      LT:  alu_res = {3'b000, alu_a < alu_b};
      EQ:  alu_res = {3'b000, alu_a == alu_b};
      default: alu_res = '0;
    endcase
  end

  typedef struct {
    logic [3:0] res;
    logic       car;
    logic       of;
    logic       zero;
    logic       scar;
    logic       sof;
    logic [1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic       m_sc, m_so;
  logic [1:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a response is consumed on the edge following a negedge that
  // sees valid and ready together.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got res=%0h expected no response at %0t", rsp_res, $time);
      end else begin
        e = sb.pop_front();
        chk("rsp_res",    32'(rsp_res),    32'(e.res));
        chk("rsp_car",    32'(rsp_car),    32'(e.car));
        chk("rsp_of",     32'(rsp_of),     32'(e.of));
        chk("rsp_zero",   32'(rsp_zero),   32'(e.zero));
        chk("sticky_car", 32'(sticky_car), 32'(e.scar));
        chk("sticky_of",  32'(sticky_of),  32'(e.sof));
        chk("op_count",   32'(op_count),   32'(e.cnt));
      end
    end
  end

  // Issue one operation with hand-computed expected result; optionally pulse
  // clr_flags during CAPT and/or withhold rsp_ready for 'hold' cycles.
  task automatic do_op(input alu_op_e op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] er, input logic ec, input logic eo, input logic ez,
                       input bit clr_capt, input int hold);
    exp_t e;
    int   n;
    if (clr_capt) begin
      m_sc = ec;
      m_so = eo;
    end else begin
      m_sc = m_sc | ec;
      m_so = m_so | eo;
    end
    m_cnt = (m_cnt == 2'd3) ? 2'd3 : m_cnt + 2'd1;
    e.res = er; e.car = ec; e.of = eo; e.zero = ez;
    e.scar = m_sc; e.sof = m_so; e.cnt = m_cnt;
    sb.push_back(e);

    if (hold > 0) rsp_ready = 1'b0;
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    @(posedge clk); #1;            // accept edge -> DRIVE
    req_valid = 1'b0;
    chk("alu_a",         32'(alu_a),     32'(a));
    chk("alu_b",         32'(alu_b),     32'(b));
    chk("alu_ctrl",      32'(alu_ctrl),  32'(op));
    chk("drive_valid",   32'(rsp_valid), 32'd0);
    chk("drive_ready",   32'(req_ready), 32'd0);
    @(posedge clk); #1;            // CAPT
    chk("capt_valid",    32'(rsp_valid), 32'd0);
    if (clr_capt) clr_flags = 1'b1;
    @(posedge clk); #1;            // third edge counting the accept edge -> RESP
    clr_flags = 1'b0;
    chk("latency_valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_a     = ~a;
      @(posedge clk); #1;
      chk("bp_valid",  32'(rsp_valid), 32'd1);
      chk("bp_res",    32'(rsp_res),   32'(er));
      chk("bp_ready",  32'(req_ready), 32'd0);
      chk("bp_alu_a",  32'(alu_a),     32'(a));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;            // handshake edge -> IDLE
    chk("rsp_drop",   32'(rsp_valid), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd1);
    chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    chk({tag, "_alu_a"},      32'(alu_a),      32'd0);
    chk({tag, "_alu_b"},      32'(alu_b),      32'd0);
    chk({tag, "_alu_ctrl"},   32'(alu_ctrl),   32'd0);
    chk({tag, "_rsp_res"},    32'(rsp_res),    32'd0);
    chk({tag, "_rsp_flags"},  32'({rsp_car, rsp_of, rsp_zero}), 32'd0);
    chk({tag, "_sticky"},     32'({sticky_car, sticky_of}),     32'd0);
    chk({tag, "_op_count"},   32'(op_count),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = ADD;
    rsp_ready = 1'b1; clr_flags = 1'b0;
    m_sc = 1'b0; m_so = 1'b0; m_cnt = 2'd0;
    @(posedge clk); @(posedge clk); #1;
    chk_all_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(ADD, 4'd7,    4'd9,    4'd0,    1'b1, 1'b0, 1'b1, 1'b0, 0);
    do_op(ADD, 4'd5,    4'd4,    4'd9,    1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("sticky_car_set", 32'(sticky_car), 32'd1);
    chk("sticky_of_set",  32'(sticky_of),  32'd1);
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    m_sc = 1'b0; m_so = 1'b0;
    chk("clr_sticky_car", 32'(sticky_car), 32'd0);
    chk("clr_sticky_of",  32'(sticky_of),  32'd0);

    do_op(AND, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    do_op(SUB, 4'd3,    4'd5,    4'hE,    1'b0, 1'b0, 1'b0, 1'b0, 5);
    do_op(ADD, 4'd8,    4'd8,    4'd0,    1'b1, 1'b1, 1'b1, 1'b1, 0);
    do_op(OR,  4'b1010, 4'b0101, 4'hF,    1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Reset while in DRIVE: the operation is abandoned.
    req_a = 4'd3; req_b = 4'd3; req_op = ADD; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("midop_in_drive", 32'(req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk_all_reset("midop");
    m_sc = 1'b0; m_so = 1'b0; m_cnt = 2'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
    end

    do_op(EQ,  4'd6,    4'd6,    4'd1,    1'b0, 1'b0, 1'b0, 1'b0, 0);
    do_op(LT,  4'd2,    4'd9,    4'd1,    1'b0, 1'b0, 1'b0, 1'b0, 0);
    do_op(NOT, 4'b0011, 4'd0,    4'b1100, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    do_op(XOR, 4'b0110, 4'b0110, 4'd0,    1'b0, 1'b0, 1'b1, 1'b0, 0);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
